// File: rtl/controle_cronometro.sv
// controle_cronometro: BCD stopwatch controller (IDLE/RUN/PAUSE) with prescaled cascaded decimal count.
// Define CRONOMETRO_LAP_EN to add the lap/hold display register.
module controle_cronometro #(
    parameter int DIGITS   = 4,
    parameter int TICK_DIV = 10
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start_stop,
    input  logic                  clear,
    input  logic                  lap,
    output logic [4*DIGITS-1:0]   bcd,
    output logic                  running,
    output logic                  overflow,
    output logic [1:0]            state
);
    typedef enum logic [1:0] {IDLE = 2'b00, RUN = 2'b01, PAUSE = 2'b10} state_t;
    localparam logic [15:0] TOP = 16'(TICK_DIV - 1);
    state_t st, st_nxt;
    logic [15:0] pres;
    logic [4*DIGITS-1:0] cnt, cnt_inc, cnt_nxt, disp_nxt;
    logic do_clear, tick, carry, wrap;
    assign state    = st;
    assign do_clear = clear && (st == IDLE || st == PAUSE);
    assign tick     = st == RUN && pres == TOP;
    assign st_nxt   = st == RUN ? (start_stop ? PAUSE : RUN) :
                      (st == IDLE || st == PAUSE) ? (clear ? IDLE : start_stop ? RUN : st) : IDLE;
    always_comb begin
        carry   = tick;
        cnt_inc = cnt;
        for (int i = 0; i < DIGITS; i++) begin
            cnt_inc[4*i+:4] = carry ? (cnt[4*i+:4] >= 4'd9 ? 4'd0 : cnt[4*i+:4] + 4'd1) : cnt[4*i+:4];
            carry = carry && cnt[4*i+:4] == 4'd9;
        end
        wrap = carry;
    end
    assign cnt_nxt = do_clear ? '0 : cnt_inc;
`ifdef CRONOMETRO_LAP_EN
    logic hold, hold_nxt;
    assign hold_nxt = do_clear ? 1'b0 : (st == RUN && lap) ? !hold : hold;
    // a freshly set hold keeps the value already on the display
    assign disp_nxt = hold_nxt ? bcd : cnt_nxt;
    always_ff @(posedge clock or posedge reset) begin
        if (reset) hold <= 1'b0;
        else hold <= hold_nxt;
    end
`else
    logic unused_lap;
    assign unused_lap = lap;
    assign disp_nxt   = cnt_nxt;
`endif
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            st       <= IDLE;
            pres     <= '0;
            cnt      <= '0;
            overflow <= 1'b0;
            running  <= 1'b0;
            bcd      <= '0;
        end else begin
            st       <= st_nxt;
            running  <= st_nxt == RUN;
            pres     <= (do_clear || tick) ? '0 : st == RUN ? pres + 16'd1 : pres;
            cnt      <= cnt_nxt;
            overflow <= do_clear ? 1'b0 : overflow || wrap;
            bcd      <= disp_nxt;
        end
    end
endmodule

// File: tb/tb_controle_cronometro.sv
// tb_controle_cronometro: random + directed checks against an integer-count stopwatch model.
module tb_controle_cronometro;
    localparam int DIGITS = 4;
    localparam int TD     = 2;
    localparam int MOD    = 10000;
    logic clock = 1'b0, reset = 1'b1, start_stop = 1'b0, clear = 1'b0, lap = 1'b0;
    logic [15:0] bcd;
    logic running, overflow;
    logic [1:0] state;
    int checks = 0, errors = 0;
    int m_state, m_cnt, m_pre, m_ov, m_hold, m_disp;

    controle_cronometro #(.DIGITS(DIGITS), .TICK_DIV(TD)) dut (
        .clock(clock), .reset(reset), .start_stop(start_stop), .clear(clear), .lap(lap),
        .bcd(bcd), .running(running), .overflow(overflow), .state(state)
    );

    always #5 clock = ~clock;

    function automatic logic [15:0] to_bcd(int v);
        logic [15:0] r;
        r = '0;
        for (int i = 0; i < DIGITS; i++) begin
            r[4*i+:4] = 4'(v % 10);
            v = v / 10;
        end
        return r;
    endfunction

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic compare_all();
        check("bcd", 32'(bcd), 32'(to_bcd(m_disp)));
        check("running", 32'(running), 32'(m_state == 1));
        check("state", 32'(state), 32'(m_state));
        check("overflow", 32'(overflow), 32'(m_ov));
    endtask

    task automatic model_reset();
        m_state = 0; m_cnt = 0; m_pre = 0; m_ov = 0; m_hold = 0; m_disp = 0;
    endtask

    // states: 0 idle, 1 run, 2 pause; count kept as a plain integer
    task automatic model_step(logic ss, logic cl, logic lp);
        if (m_state == 1) begin
            if (m_pre == TD - 1) begin
                m_pre = 0;
                if (m_cnt == MOD - 1) m_ov = 1;
                m_cnt = (m_cnt + 1) % MOD;
            end else m_pre++;
`ifdef CRONOMETRO_LAP_EN
            if (lp) m_hold = !m_hold;
`endif
            if (ss) m_state = 2;
        end else if (cl) begin
            m_state = 0; m_cnt = 0; m_pre = 0; m_ov = 0; m_hold = 0;
        end else if (ss) m_state = 1;
        if (!m_hold) m_disp = m_cnt;
    endtask

    task automatic cycle(logic ss, logic cl, logic lp);
        start_stop = ss; clear = cl; lap = lp;
        @(posedge clock);
        model_step(ss, cl, lp);
        #1;
        compare_all();
    endtask

    task automatic do_reset();
        @(negedge clock);
        #2;
        reset = 1'b1;
        start_stop = 1'($urandom); clear = 1'($urandom); lap = 1'($urandom);
        #1;
        model_reset();
        check("rst_bcd", 32'(bcd), 32'h0);
        check("rst_state", 32'(state), 32'h0);
        compare_all();
        @(negedge clock);
        reset = 1'b0; start_stop = 1'b0; clear = 1'b0; lap = 1'b0;
        #1;
        compare_all();
    endtask

    task automatic run_until(int target, int bound);
        for (int n = 0; n < bound && m_cnt != target; n++) cycle(1'b0, 1'b0, 1'b0);
        check("reach", 32'(m_cnt), 32'(target));
    endtask

    initial begin
        model_reset();
        #12;
        check("reset_bcd", 32'(bcd), 32'h0);
        check("reset_run", 32'(running), 32'h0);
        check("reset_ovf", 32'(overflow), 32'h0);
        check("reset_state", 32'(state), 32'h0);
        @(negedge clock);
        reset = 1'b0;
        // first increment latency and decade carry
        cycle(1'b1, 1'b0, 1'b0);
        check("run_rise", 32'(running), 32'h1);
        cycle(1'b0, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 1'b0);
        check("first_inc", 32'(bcd), 32'h0001);
        for (int i = 0; i < 18; i++) cycle(1'b0, 1'b0, 1'b0);
        check("carry_10", 32'(bcd), 32'h0010);
        // pause mid-period keeps the partial period
        cycle(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 50; i++) cycle(1'b0, 1'b0, 1'b0);
        check("pause_hold", 32'(bcd), 32'h0010);
        cycle(1'b1, 1'b0, 1'b0);
        check("resume_edge", 32'(bcd), 32'h0010);
        cycle(1'b0, 1'b0, 1'b0);
        check("resume_inc", 32'(bcd), 32'h0011);
        // clear + start_stop together
        cycle(1'b1, 1'b1, 1'b0);
        check("cs_run_state", 32'(state), 32'h2);
        check("cs_run_bcd", 32'(bcd), 32'h0011);
        cycle(1'b1, 1'b1, 1'b0);
        check("cs_pause_state", 32'(state), 32'h0);
        check("cs_pause_bcd", 32'(bcd), 32'h0000);
        // asynchronous reset mid-count
        cycle(1'b1, 1'b0, 1'b0);
        run_until(42, 200);
        check("pre_rst_bcd", 32'(bcd), 32'h0042);
        do_reset();
        // lap / hold (or lap ignored in the default build)
        cycle(1'b1, 1'b0, 1'b0);
        run_until(5, 100);
        cycle(1'b0, 1'b0, 1'b1);
`ifdef CRONOMETRO_LAP_EN
        for (int i = 0; i < 20; i++) begin
            cycle(1'b0, 1'b0, 1'b0);
            check("lap_hold", 32'(bcd), 32'h0005);
        end
        cycle(1'b0, 1'b0, 1'b1);
        check("lap_live", 32'(bcd), 32'(to_bcd(m_cnt)));
`else
        for (int i = 0; i < 20; i++) cycle(1'b0, 1'b0, 1'b0);
        check("lap_ignored", 32'(bcd), 32'(to_bcd(m_cnt)));
`endif
        // overflow wrap and sticky flag
        cycle(1'b1, 1'b0, 1'b0);
        cycle(1'b0, 1'b1, 1'b0);
        cycle(1'b1, 1'b0, 1'b0);
        run_until(9998, 25000);
        check("pre_9998", 32'(bcd), 32'h9998);
        run_until(9999, 10);
        check("at_9999", 32'(bcd), 32'h9999);
        check("no_ovf_yet", 32'(overflow), 32'h0);
        run_until(0, 10);
        check("wrap_bcd", 32'(bcd), 32'h0000);
        check("wrap_ovf", 32'(overflow), 32'h1);
        for (int i = 0; i < 6; i++) cycle(1'b0, 1'b0, 1'b0);
        cycle(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) cycle(1'b0, 1'b1 & (i == 9), 1'b0);
        check("ovf_sticky", 32'(overflow), 32'h1);
        cycle(1'b0, 1'b1, 1'b0);
        check("ovf_cleared", 32'(overflow), 32'h0);
        // randomized pulses
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 499) == 0) do_reset();
            else cycle($urandom_range(0, 9) == 0, $urandom_range(0, 19) == 0, $urandom_range(0, 9) == 0);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
